lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store stage directly downstream of the ALU: takes the ALU result as effective address (or as plain result for
//  non-memory ops), performs one memory transaction over a valid/ready bus, aligns/extends load data, hands result to WBU.
//  One instruction in flight; upstream/downstream decoupled by valid/ready handshakes.
// PARAMETERS
//  TIMEOUT     255   cycles allowed in WAIT for mem_resp_valid before aborting with err (8-bit counter; 1..255)
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  in_valid        in   1   EXU presents an instruction
//  in_ready        out  1   LSU can accept (state==IDLE)
//  in_addr         in   32  ALU result (effective address or pass-through result)
//  in_wdata        in   32  rs2 value for stores
//  in_funct3       in   3   width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  in_load         in   1   instruction is a load
//  in_store        in   1   instruction is a store (in_load&in_store both set -> err)
//  mem_req_valid   out  1   bus request valid
//  mem_req_ready   in   1   bus accepts request
//  mem_req_addr    out  32  word-aligned address ({in_addr[31:2],2'b00})
//  mem_req_wen     out  1   1 = write
//  mem_req_wdata   out  32  store data shifted into byte lanes
//  mem_req_wmask   out  4   byte-lane write enables (0 for reads)
//  mem_resp_valid  in   1   read data / write ack, one-cycle pulse
//  mem_resp_data   in   32  raw word read
//  out_valid       out  1   result ready for WBU
//  out_ready       in   1   WBU accepts
//  out_data        out  32  extended load data, or in_addr for non-memory ops, 0 for stores/err
//  out_err         out  1   misaligned, illegal funct3/op combination, or bus timeout
// BEHAVIOUR
//  Reset: state=IDLE, all registered outputs 0, timeout counter 0; in_ready=1 while in IDLE (incl. during reset).
//  FSM IDLE->REQ->WAIT->DONE->IDLE; all request fields registered at acceptance (in_valid&in_ready), held stable.
//  IDLE: on accept: non-memory op -> DONE (out_data=in_addr, err=0); illegal/misaligned -> DONE, err=1, no bus access;
//    else -> REQ. Misaligned: H with addr[0]=1, W with addr[1:0]!=0. Illegal: load&store, store funct3 in {100,101,11x},
//    load funct3 in {011,11x}.
//  REQ: mem_req_valid=1; fields must not change until mem_req_ready; on ready -> WAIT, counter cleared.
//  WAIT: counter++ each cycle; on mem_resp_valid -> DONE (load: capture+extend; store: out_data=0);
//    counter reaching TIMEOUT without resp -> DONE with err=1. resp and timeout same cycle: resp wins.
//  DONE: out_valid=1, data/err stable until out_ready; on out_ready -> IDLE (no same-cycle re-accept).
//  mem_resp_valid in IDLE/REQ/DONE is ignored (stale responses after reset/timeout dropped).
//  Min latency accept->out_valid: 1 cycle non-mem/err, 3 cycles mem with ready=1 and resp next cycle.
//  Store lanes: B wmask=4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; wdata=in_wdata<<(8*addr[1:0]).
//  Load: shift raw word right by 8*addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU) to 32 bits.
//  Reset mid-transaction: abandon immediately, return to IDLE, drop mem_req_valid/out_valid asynchronously.
// STRUCTURE
//  defines.v: `LSU_B/`LSU_H/`LSU_W/`LSU_BU/`LSU_HU funct3 codes; `LSU_IDLE/REQ/WAIT/DONE 2-bit state encodings.
//  Sub-module lsu_align (combinational): store lane shift+wmask, load shift+extend, misalign/illegal detect.
// TESTING
//  LW addr=0x80000004, resp 0xDEADBEEF -> req_addr 0x80000004, wmask 0, out_data 0xDEADBEEF, err 0, out_valid at +3.
//  LB addr=..03 resp 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr=..02 -> 0xFFFF8011; LHU -> 0x00008011.
//  SH addr=..02 wdata 0x0000ABCD -> wmask 4'b1100, req_wdata 0xABCD0000, wen 1; ack -> out_valid, out_data 0.
//  LW addr=..02 / SH addr=..01 -> no mem_req_valid, out_err=1 one cycle after accept.
//  mem_req_ready low 5 cycles then high; out_ready low 3 cycles -> req fields and out_data held stable, in_ready 0.
//  No resp for TIMEOUT cycles -> out_err=1; late resp afterwards ignored; rst_n pulse in WAIT -> IDLE, outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
  } mem_req_t;

endpackage

// File: rtl/lsu_if.sv
// Upstream, memory-bus and writeback handshakes of the LSU; slave is the LSU side.
interface lsu_if;
  import lsu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [2:0]      in_funct3;
  logic            in_load;
  logic            in_store;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wmask;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_funct3, in_load, in_store,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output out_valid, out_data, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_funct3, in_load, in_store,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  out_valid, out_data, out_err,
    output out_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store shift/mask, load shift/extend, misalign/illegal checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  input  logic            load,
  input  logic            store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_sh,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign,
  output logic            illegal
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] rsh;

  assign shamt = {off, 3'b000};
  assign rsh   = rdata >> shamt;

  always_comb begin
    wdata_sh  = '0;
    wmask     = 4'b0000;
    rdata_ext = '0;
    if (store) begin
      wdata_sh = wdata << shamt;
      case (funct3)
        F3_B:    wmask = 4'b0001 << off;
        F3_H:    wmask = 4'b0011 << off;
        F3_W:    wmask = 4'b1111;
        default: wmask = 4'b0000;
      endcase
    end
    case (funct3)
      F3_B:    rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    rdata_ext = {{16{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_ext = rsh;
      F3_BU:   rdata_ext = {24'd0, rsh[7:0]};
      F3_HU:   rdata_ext = {16'd0, rsh[15:0]};
      default: rdata_ext = '0;
    endcase
  end

  // Halfword covers H and HU; word is only W.
  assign misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3 == F3_W) && (off != 2'b00));

  assign illegal = (load && store) ||
                   (store && funct3[2]) ||
                   (load && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11)));

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction in flight, IDLE->REQ->WAIT->DONE over a valid/ready bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  state_e           state_q, state_d;
  mem_req_t         req_q, req_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             req_valid_q, req_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             idle_c;
  logic             mem_op_c;
  logic [1:0]       a_off_c;
  logic [2:0]       a_f3_c;
  logic             a_load_c, a_store_c;
  logic [XLEN-1:0]  a_wdata_c, a_rdata_c;
  logic [3:0]       a_wmask_c;
  logic             a_misalign_c, a_illegal_c;

  assign idle_c   = (state_q == ST_IDLE);
  assign mem_op_c = bus.in_load | bus.in_store;

  // In IDLE the aligner inspects the incoming op; afterwards it works on the captured one.
  assign a_off_c   = idle_c ? bus.in_addr[1:0] : off_q;
  assign a_f3_c    = idle_c ? bus.in_funct3    : f3_q;
  assign a_load_c  = idle_c ? bus.in_load      : load_q;
  assign a_store_c = idle_c ? bus.in_store     : req_q.wen;

  lsu_align u_align (
    .off       (a_off_c),
    .funct3    (a_f3_c),
    .load      (a_load_c),
    .store     (a_store_c),
    .wdata     (bus.in_wdata),
    .rdata     (bus.mem_resp_data),
    .wdata_sh  (a_wdata_c),
    .wmask     (a_wmask_c),
    .rdata_ext (a_rdata_c),
    .misalign  (a_misalign_c),
    .illegal   (a_illegal_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      load_q      <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    off_d      = off_q;
    f3_d       = f3_q;
    load_d     = load_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          out_data_d = '0;
          out_err_d  = 1'b0;
          if (!mem_op_c) begin
            out_data_d = bus.in_addr;
            state_d    = ST_DONE;
          end else if (a_illegal_c || a_misalign_c) begin
            out_err_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            req_d.addr  = {bus.in_addr[31:2], 2'b00};
            req_d.wen   = bus.in_store;
            req_d.wdata = a_wdata_c;
            req_d.wmask = a_wmask_c;
            off_d       = bus.in_addr[1:0];
            f3_d        = bus.in_funct3;
            load_d      = bus.in_load;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the same cycle as the timeout still completes normally.
        if (bus.mem_resp_valid) begin
          out_data_d = load_q ? a_rdata_c : '0;
          out_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_valid_d = (state_d == ST_REQ);
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_wen   = req_q.wen;
  assign bus.mem_req_wdata = req_q.wdata;
  assign bus.mem_req_wmask = req_q.wmask;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: alignment, extension, errors, stalls, timeout and reset.
module tb_lsu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lsu_if bus ();

  lsu #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid       = 1'b0;
    bus.in_addr        = '0;
    bus.in_wdata       = '0;
    bus.in_funct3      = 3'b000;
    bus.in_load        = 1'b0;
    bus.in_store       = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.out_ready      = 1'b0;
  endtask

  // Present one op for exactly one cycle; the LSU is idle so it is accepted on that edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic ld, input logic st);
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_funct3 = f3;
    bus.in_load   = ld;
    bus.in_store  = st;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Grant the request at once, answer one cycle after the grant.
  task automatic serve(input logic [31:0] rdata);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== 32'd0 || bus.out_err !== 1'b0 || bus.mem_req_wmask !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b reqv=%b outv=%b data=%h err=%b wmask=%b, required 1 0 0 0 0 0",
               bus.in_ready, bus.mem_req_valid, bus.out_valid, bus.out_data, bus.out_err,
               bus.mem_req_wmask);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    issue(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0004 ||
        bus.mem_req_wmask !== 4'd0 || bus.mem_req_wen !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_req: v=%b addr=%h wmask=%b wen=%b rdy=%b, required 1 80000004 0000 0 0",
               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wen, bus.in_ready);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_wait: reqv=%b outv=%b, required 0 0", bus.mem_req_valid, bus.out_valid);
    end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_out: v=%b data=%h err=%b, required 1 deadbeef 0",
               bus.out_valid, bus.out_data, bus.out_err);
    end
    retire();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_retire: outv=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] addr_t [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                32'h8000_0002, 32'h8000_0000, 32'h8000_0000};
    logic [2:0]  f3_t   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] exp_t  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011,
                                32'h0000_8011, 32'h0000_0033, 32'h0000_2233};
    for (int i = 0; i < 6; i++) begin
      issue(addr_t[i], 32'h0, f3_t[i], 1'b1, 1'b0);
      serve(32'h8011_2233);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_t[i] || bus.out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: v=%b data=%h err=%b, required 1 %h 0",
                 i, bus.out_valid, bus.out_data, bus.out_err, exp_t[i]);
      end
      retire();
    end
  endtask

  task automatic test_store();
    logic [31:0] addr_t [3] = '{32'h8000_0002, 32'h8000_0101, 32'h8000_0208};
    logic [31:0] wd_t   [3] = '{32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_F00D};
    logic [2:0]  f3_t   [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ea_t   [3] = '{32'h8000_0000, 32'h8000_0100, 32'h8000_0208};
    logic [31:0] ew_t   [3] = '{32'hABCD_0000, 32'h3456_7800, 32'hCAFE_F00D};
    logic [3:0]  em_t   [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      issue(addr_t[i], wd_t[i], f3_t[i], 1'b0, 1'b1);
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_wen !== 1'b1 || bus.mem_req_addr !== ea_t[i] ||
          bus.mem_req_wdata !== ew_t[i] || bus.mem_req_wmask !== em_t[i]) begin
        n_fail++;
        $display("FAIL store_req[%0d]: v=%b wen=%b addr=%h wdata=%h wmask=%b, required 1 1 %h %h %b",
                 i, bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata,
                 bus.mem_req_wmask, ea_t[i], ew_t[i], em_t[i]);
      end
      serve(32'h5555_5555);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0 || bus.out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL store_ack[%0d]: v=%b data=%h err=%b, required 1 0 0",
                 i, bus.out_valid, bus.out_data, bus.out_err);
      end
      retire();
    end
  endtask

  task automatic test_errors();
    logic [31:0] addr_t [6] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [2:0]  f3_t   [6] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000};
    logic        ld_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        st_t   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ed_t   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5678};
    logic        ee_t   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(addr_t[i], 32'hFFFF_FFFF, f3_t[i], ld_t[i], st_t[i]);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.mem_req_valid !== 1'b0 ||
          bus.out_data !== ed_t[i] || bus.out_err !== ee_t[i]) begin
        n_fail++;
        $display("FAIL err_case[%0d]: outv=%b reqv=%b data=%h err=%b, required 1 0 %h %b",
                 i, bus.out_valid, bus.mem_req_valid, bus.out_data, bus.out_err, ed_t[i], ee_t[i]);
      end
      retire();
    end
  endtask

  task automatic test_stall();
    issue(32'h0000_0040, 32'h0, 3'b010, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_addr  = 32'h0000_0080;
    bus.in_store = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_0040 ||
          bus.mem_req_wen !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req[%0d]: v=%b addr=%h wen=%b rdy=%b, required 1 00000040 0 0",
                 i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_store = 1'b0;
    serve(32'h0BAD_F00D);
    bus.mem_resp_data = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0BAD_F00D || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_out[%0d]: v=%b data=%h rdy=%b, required 1 0badf00d 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    bus.mem_resp_data = '0;
    retire();
  endtask

  task automatic test_back_to_back();
    issue(32'hAAAA_0001, 32'h0, 3'b000, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'hBBBB_0002;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: outv=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hBBBB_0002) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b data=%h, required 1 bbbb0002", bus.out_valid, bus.out_data);
    end
    retire();
  endtask

  task automatic test_timeout();
    int n;
    issue(32'h0000_0100, 32'h0, 3'b010, 1'b1, 1'b0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 255 || bus.out_err !== 1'b1 || bus.out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout: cycles=%0d err=%b data=%h, required 255 1 0", n, bus.out_err, bus.out_data);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h7777_7777;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL late_resp: v=%b err=%b data=%h, required 1 1 0", bus.out_valid, bus.out_err, bus.out_data);
    end
    retire();
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_resp: outv=%b reqv=%b rdy=%b, required 0 0 1",
               bus.out_valid, bus.mem_req_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_0200, 32'h0, 3'b010, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req: reqv=%b rdy=%b, required 0 1", bus.mem_req_valid, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    issue(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 ||
        bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait: reqv=%b outv=%b data=%h err=%b rdy=%b, required 0 0 0 0 1",
               bus.mem_req_valid, bus.out_valid, bus.out_data, bus.out_err, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h9999_9999;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stale: outv=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    issue(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0);
    serve(32'h0123_4567);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0123_4567 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: v=%b data=%h err=%b, required 1 01234567 0",
               bus.out_valid, bus.out_data, bus.out_err);
    end
    retire();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_errors();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
